// File: rtl/hier_node_ctrl.sv
// -----------------------------------------------------------------------------
// hier_node_ctrl
//
// Hierarchy node controller. It accepts one command from the parent and
// broadcasts the latched payload to a selected subset of children. Each
// selected child gets its own valid/ready handshake. The node then collects
// one completion pulse, with an error flag, from each selected child. A single
// aggregated response goes back upstream. A completion timeout is optional
// (TIMEOUT_CYCLES = 0 disables it).
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   req_valid      parent command valid
//   req_ready      node can accept a command (IDLE only)
//   req_data       command payload
//   req_mask       children selected for this command
//   child_valid    per-child command valid (pending issues while ACTIVE)
//   child_ready    per-child command accept
//   child_data     latched payload, broadcast to all children
//   child_done     per-child one-cycle completion pulse
//   child_err      per-child error flag, sampled only with child_done
//   rsp_valid      aggregated response valid (RESP)
//   rsp_ready      parent accepts response
//   rsp_err_mask   children that reported an error with their done
//   rsp_pend_mask  selected children that never completed (timeout only)
//   rsp_timeout    response was caused by the timeout
// -----------------------------------------------------------------------------
module hier_node_ctrl #(
  parameter int NUM_CHILDREN   = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_W-1:0]       req_data,
  input  logic [NUM_CHILDREN-1:0] req_mask,
  output logic [NUM_CHILDREN-1:0] child_valid,
  input  logic [NUM_CHILDREN-1:0] child_ready,
  output logic [DATA_W-1:0]       child_data,
  input  logic [NUM_CHILDREN-1:0] child_done,
  input  logic [NUM_CHILDREN-1:0] child_err,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [NUM_CHILDREN-1:0] rsp_err_mask,
  output logic [NUM_CHILDREN-1:0] rsp_pend_mask,
  output logic                    rsp_timeout
);

  // The counter needs at least one bit even when the timeout is disabled.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_CHILDREN-1:0] issue_q, issue_d;   // children not yet handshaken
  logic [NUM_CHILDREN-1:0] done_q, done_d;     // children not yet completed
  logic [NUM_CHILDREN-1:0] err_q, err_d;
  logic [NUM_CHILDREN-1:0] pend_q, pend_d;     // snapshot of done_q on timeout
  logic                    to_q, to_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]       data_q, data_d;
  // Cleared by reset and set on the first edge out of reset. This keeps
  // req_ready low while reset is held, even though the state is already IDLE.
  logic                    en_q;

  logic [NUM_CHILDREN-1:0] accepted;
  logic [NUM_CHILDREN-1:0] done_hit;

  // A child is eligible to complete once it has handshaken, including in
  // the same cycle as its done pulse.
  assign accepted = ~issue_q | child_ready;
  assign done_hit = child_done & done_q & accepted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      issue_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      pend_q  <= '0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    done_d  = done_q;
    err_d   = err_q;
    pend_d  = pend_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          data_d  = req_data;
          issue_d = req_mask;
          done_d  = req_mask;
          err_d   = '0;
          pend_d  = '0;
          to_d    = 1'b0;
          cnt_d   = '0;
          state_d = (req_mask == '0) ? RESP : ACTIVE;
        end
      end

      ACTIVE: begin
        issue_d = issue_q & ~child_ready;
        done_d  = done_q & ~done_hit;
        err_d   = err_q | (done_hit & child_err);
        if (TO_EN) cnt_d = cnt_q + CW'(1);
        // Completion takes priority over a timeout in the same cycle.
        if (done_d == '0) begin
          state_d = RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          to_d    = 1'b1;
          pend_d  = done_d;
          issue_d = '0;
        end
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = en_q && (state_q == IDLE);
  assign child_valid   = (state_q == ACTIVE) ? issue_q : '0;
  assign child_data    = data_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_err_mask  = (state_q == RESP) ? err_q  : '0;
  assign rsp_pend_mask = (state_q == RESP) ? pend_q : '0;
  assign rsp_timeout   = (state_q == RESP) && to_q;

endmodule

// File: tb/tb_hier_node_ctrl.sv
module tb_hier_node_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [4:0] req_mask;
  logic [4:0] child_valid;
  logic [4:0] child_ready;
  logic [7:0] child_data;
  logic [4:0] child_done;
  logic [4:0] child_err;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_err_mask;
  logic [4:0] rsp_pend_mask;
  logic       rsp_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hier_node_ctrl #(
    .NUM_CHILDREN  (5),
    .DATA_W        (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_mask     (req_mask),
    .child_valid  (child_valid),
    .child_ready  (child_ready),
    .child_data   (child_data),
    .child_done   (child_done),
    .child_err    (child_err),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_err_mask (rsp_err_mask),
    .rsp_pend_mask(rsp_pend_mask),
    .rsp_timeout  (rsp_timeout)
  );

  typedef struct {
    logic       rst_n;
    logic       rv;
    logic [7:0] d;
    logic [4:0] m;
    logic [4:0] r;
    logic [4:0] dn;
    logic [4:0] er;
    logic       rr;
    logic       e_rq;
    logic [4:0] e_cv;
    logic [7:0] e_d;
    logic       e_rv;
    logic [4:0] e_err;
    logic [4:0] e_pend;
    logic       e_to;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rn, input logic rv, input logic [7:0] d,
                     input logic [4:0] m, input logic [4:0] r,
                     input logic [4:0] dn, input logic [4:0] er,
                     input logic rr, input logic erq, input logic [4:0] ecv,
                     input logic [7:0] ed, input logic erv,
                     input logic [4:0] eer, input logic [4:0] epd,
                     input logic eto);
    vec_t v;
    v.rst_n = rn; v.rv = rv; v.d = d; v.m = m; v.r = r; v.dn = dn;
    v.er = er; v.rr = rr; v.e_rq = erq; v.e_cv = ecv; v.e_d = ed;
    v.e_rv = erv; v.e_err = eer; v.e_pend = epd; v.e_to = eto;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rn, input logic rv, input logic [7:0] d,
                       input logic [4:0] m, input logic [4:0] r,
                       input logic [4:0] dn, input logic [4:0] er,
                       input logic rr);
    rst_n = rn; req_valid = rv; req_data = d; req_mask = m;
    child_ready = r; child_done = dn; child_err = er; rsp_ready = rr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", name, row, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int row,
                            input logic erq, input logic [4:0] ecv,
                            input logic [7:0] ed, input logic erv,
                            input logic [4:0] eer, input logic [4:0] epd,
                            input logic eto);
    chk({tag, ".req_ready"},     row, 32'(req_ready),     32'(erq));
    chk({tag, ".child_valid"},   row, 32'(child_valid),   32'(ecv));
    chk({tag, ".child_data"},    row, 32'(child_data),    32'(ed));
    chk({tag, ".rsp_valid"},     row, 32'(rsp_valid),     32'(erv));
    chk({tag, ".rsp_err_mask"},  row, 32'(rsp_err_mask),  32'(eer));
    chk({tag, ".rsp_pend_mask"}, row, 32'(rsp_pend_mask), 32'(epd));
    chk({tag, ".rsp_timeout"},   row, 32'(rsp_timeout),   32'(eto));
    $display("%s step %0d: req_ready=%b child_valid=%b data=%h rsp_valid=%b err=%b pend=%b to=%b",
             tag, row, req_ready, child_valid, child_data, rsp_valid,
             rsp_err_mask, rsp_pend_mask, rsp_timeout);
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1'b0);

    //   rn rv data   mask   rdy    done   err    rr | rq cv     data   rv err    pend   to
    // reset held: every output 0
    add(0, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0,  0, 5'h00, 8'h00, 0, 5'h00, 5'h00, 0);
    add(0, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0,  0, 5'h00, 8'h00, 0, 5'h00, 5'h00, 0);
    add(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0,  1, 5'h00, 8'h00, 0, 5'h00, 5'h00, 0);
    // full mask, all complete in the first ACTIVE cycle -> 2-cycle latency
    add(1, 1, 8'hA5, 5'h1F, 5'h1F, 5'h00, 5'h00, 0,  0, 5'h1F, 8'hA5, 0, 5'h00, 5'h00, 0);
    add(1, 0, 8'h00, 5'h00, 5'h1F, 5'h1F, 5'h00, 0,  0, 5'h00, 8'hA5, 1, 5'h00, 5'h00, 0);
    add(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1,  1, 5'h00, 8'hA5, 0, 5'h00, 5'h00, 0);
    // mask 10100: child 4 ready at once, child 2 late; stray and early dones ignored
    add(1, 1, 8'h3C, 5'h14, 5'h00, 5'h00, 5'h00, 0,  0, 5'h14, 8'h3C, 0, 5'h00, 5'h00, 0);
    add(1, 0, 8'h00, 5'h00, 5'h10, 5'h01, 5'h01, 0,  0, 5'h04, 8'h3C, 0, 5'h00, 5'h00, 0);
    add(1, 0, 8'h00, 5'h00, 5'h00, 5'h15, 5'h10, 0,  0, 5'h04, 8'h3C, 0, 5'h00, 5'h00, 0);
    add(1, 0, 8'h00, 5'h00, 5'h04, 5'h04, 5'h00, 0,  0, 5'h00, 8'h3C, 1, 5'h10, 5'h00, 0);
    add(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1,  1, 5'h00, 8'h3C, 0, 5'h00, 5'h00, 0);
    // empty mask -> response next cycle, held while rsp_ready low
    add(1, 1, 8'h77, 5'h00, 5'h00, 5'h00, 5'h00, 0,  0, 5'h00, 8'h77, 1, 5'h00, 5'h00, 0);
    add(1, 1, 8'hEE, 5'h1F, 5'h1F, 5'h00, 5'h00, 0,  0, 5'h00, 8'h77, 1, 5'h00, 5'h00, 0);
    add(1, 1, 8'hEE, 5'h1F, 5'h1F, 5'h00, 5'h00, 0,  0, 5'h00, 8'h77, 1, 5'h00, 5'h00, 0);
    add(1, 1, 8'hEE, 5'h1F, 5'h1F, 5'h00, 5'h00, 0,  0, 5'h00, 8'h77, 1, 5'h00, 5'h00, 0);
    add(1, 1, 8'hEE, 5'h1F, 5'h1F, 5'h00, 5'h00, 0,  0, 5'h00, 8'h77, 1, 5'h00, 5'h00, 0);
    add(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1,  1, 5'h00, 8'h77, 0, 5'h00, 5'h00, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].rv, tbl[i].d, tbl[i].m, tbl[i].r,
            tbl[i].dn, tbl[i].er, tbl[i].rr);
      step();
      expect_out("vec", i, tbl[i].e_rq, tbl[i].e_cv, tbl[i].e_d, tbl[i].e_rv,
                 tbl[i].e_err, tbl[i].e_pend, tbl[i].e_to);
    end

    // Timeout: child 0 completes, child 1 never accepts -> RESP after 8 ACTIVE cycles
    drive(1, 1, 8'h5A, 5'h03, 5'h1F, 5'h00, 5'h00, 0);
    step(); expect_out("tmo", 0, 0, 5'h03, 8'h5A, 0, 5'h00, 5'h00, 0);
    drive(1, 0, 8'h00, 5'h00, 5'h01, 5'h01, 5'h00, 0);
    step(); expect_out("tmo", 1, 0, 5'h02, 8'h5A, 0, 5'h00, 5'h00, 0);
    drive(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0);
    for (int k = 2; k <= 7; k++) begin
      step(); expect_out("tmo", k, 0, 5'h02, 8'h5A, 0, 5'h00, 5'h00, 0);
    end
    step(); expect_out("tmo", 8, 0, 5'h00, 8'h5A, 1, 5'h00, 5'h02, 1);
    drive(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1);
    step(); expect_out("tmo", 9, 1, 5'h00, 8'h5A, 0, 5'h00, 5'h00, 0);

    // Last done on the 8th ACTIVE cycle: completion wins over timeout
    drive(1, 1, 8'h96, 5'h03, 5'h00, 5'h00, 5'h00, 0);
    step(); expect_out("race", 0, 0, 5'h03, 8'h96, 0, 5'h00, 5'h00, 0);
    drive(1, 0, 8'h00, 5'h00, 5'h1F, 5'h01, 5'h00, 0);
    step(); expect_out("race", 1, 0, 5'h00, 8'h96, 0, 5'h00, 5'h00, 0);
    drive(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0);
    for (int k = 2; k <= 7; k++) begin
      step(); expect_out("race", k, 0, 5'h00, 8'h96, 0, 5'h00, 5'h00, 0);
    end
    drive(1, 0, 8'h00, 5'h00, 5'h00, 5'h02, 5'h02, 0);
    step(); expect_out("race", 8, 0, 5'h00, 8'h96, 1, 5'h02, 5'h00, 0);
    drive(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1);
    step(); expect_out("race", 9, 1, 5'h00, 8'h96, 0, 5'h00, 5'h00, 0);

    // Reset while ACTIVE, then a fresh command
    drive(1, 1, 8'hC3, 5'h1F, 5'h00, 5'h00, 5'h00, 0);
    step(); expect_out("rst", 0, 0, 5'h1F, 8'hC3, 0, 5'h00, 5'h00, 0);
    drive(0, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0);
    step(); expect_out("rst", 1, 0, 5'h00, 8'h00, 0, 5'h00, 5'h00, 0);
    drive(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 0);
    step(); expect_out("rst", 2, 1, 5'h00, 8'h00, 0, 5'h00, 5'h00, 0);
    drive(1, 1, 8'h11, 5'h01, 5'h00, 5'h00, 5'h00, 0);
    step(); expect_out("rst", 3, 0, 5'h01, 8'h11, 0, 5'h00, 5'h00, 0);
    drive(1, 0, 8'h00, 5'h00, 5'h01, 5'h01, 5'h00, 0);
    step(); expect_out("rst", 4, 0, 5'h00, 8'h11, 1, 5'h00, 5'h00, 0);
    drive(1, 0, 8'h00, 5'h00, 5'h00, 5'h00, 5'h00, 1);
    step(); expect_out("rst", 5, 1, 5'h00, 8'h11, 0, 5'h00, 5'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hier_node_ctrl.md
# hier_node_ctrl

Parametrised hierarchy node controller for the generated module tree. It accepts one command from its parent, broadcasts it to a selectable subset of NUM_CHILDREN child instances over per-child valid/ready handshakes, and collects a completion pulse (with error flag) from each selected child. It then returns a single aggregated response upstream. Unlike the fixed five-child structural node, child count, payload width and a completion timeout are generic, and per-child selection, handshaking and status aggregation are added.

## Interface
Parameters:
- NUM_CHILDREN, 5, number of child ports (1..32)
- DATA_W, 8, command payload width
- TIMEOUT_CYCLES, 255, maximum cycles spent in ACTIVE; 0 disables the timeout
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  parent command valid
- req_ready  out  1  node can accept a command
- req_data  in  DATA_W  command payload
- req_mask  in  NUM_CHILDREN  children selected for this command
- child_valid  out  NUM_CHILDREN  per-child command valid
- child_ready  in  NUM_CHILDREN  per-child command accept
- child_data  out  DATA_W  latched payload, broadcast to all children
- child_done  in  NUM_CHILDREN  per-child one-cycle completion pulse
- child_err  in  NUM_CHILDREN  error flag, sampled only with child_done
- rsp_valid  out  1  aggregated response valid
- rsp_ready  in  1  parent accepts response
- rsp_err_mask  out  NUM_CHILDREN  children that reported err with done
- rsp_pend_mask  out  NUM_CHILDREN  selected children that never completed (timeout only)
- rsp_timeout  out  1  response was caused by timeout

## Operation
- States: IDLE, ACTIVE, RESP. Reset (rst_n low at a clock edge) forces IDLE and clears all registers. While in reset, every output is 0, including req_ready.
- IDLE: req_ready=1. When req_valid&req_ready:
  - latch req_data to child_data
  - issue_pend = done_pend = req_mask; err_mask = 0; counter = 0
  - req_mask==0: go to RESP with all status 0; otherwise go to ACTIVE.
- ACTIVE: child_valid = issue_pend. A child_valid[i]&child_ready[i] handshake clears issue_pend[i]. child_valid[i] stays high until its handshake; it is never dropped early except on timeout.
- A completion is counted when child_done[i]=1, done_pend[i]=1, and the child has already handshaken or is handshaking in the same cycle. Counting clears done_pend[i] and ORs child_err[i] into err_mask[i].
- child_done from unselected, already-completed, or not-yet-accepted children is ignored.
- Exit ACTIVE to RESP when done_pend (after this cycle's updates) == 0. rsp_timeout=0, rsp_pend_mask=0.
- Timeout (TIMEOUT_CYCLES>0): the counter increments every ACTIVE cycle. In the cycle where counter==TIMEOUT_CYCLES-1 and done_pend is still nonzero after this cycle's updates:
  - go to RESP with rsp_timeout=1 and rsp_pend_mask=done_pend
  - clear issue_pend, so child_valid drops in RESP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE. req_ready=0 in ACTIVE and RESP.
- child_data stays stable from acceptance until return to IDLE.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- Request accepted at edge T0: child_valid is high from cycle T0+1.
- If all selected children handshake and pulse done in T0+1, rsp_valid is high in T0+2. That is the minimum latency of 2 cycles.
- Empty mask: rsp_valid in T0+1.
- At most TIMEOUT_CYCLES cycles are spent in ACTIVE.
- Completion beats timeout when the last done arrives in the timeout cycle.
- rsp accepted at edge T: req_ready=1 in T+1. Back-to-back commands are separated by at least one IDLE cycle.
- Reset mid-operation: at the next edge with rst_n low, the node is in IDLE with all outputs 0. In-flight child handshakes are abandoned.

## Test plan
- Defaults, req_mask=5'b11111, data 8'hA5, all child_ready=1, all child_done pulsed in the first ACTIVE cycle -> child_valid=5'b11111 for 1 cycle, child_data=8'hA5, rsp_valid 2 cycles after accept, rsp_err_mask=0, rsp_timeout=0.
- req_mask=5'b10100, child 2 ready after 3 cycles, child 4 ready immediately; done pulses with child_err[4]=1; stray done on child 0 -> child 0 never valid and its done is ignored, rsp_err_mask=5'b10000.
- TIMEOUT_CYCLES=8, mask=5'b00011, only child 0 completes -> rsp after exactly 8 ACTIVE cycles, rsp_timeout=1, rsp_pend_mask=5'b00010, child_valid=0 in RESP.
- Last done arrives exactly on the 8th ACTIVE cycle -> rsp_timeout=0, rsp_pend_mask=0.
- req_mask=0 -> rsp_valid next cycle with all-zero status. Hold rsp_ready=0 for 4 cycles -> response stable, req_ready=0 until 1 cycle after rsp_ready.
- Deassert rst_n during ACTIVE with child_valid high -> after that edge all outputs 0, state IDLE. A fresh command after release completes normally.
